fnd_scan_controller: RTL
========================

# fnd_scan_controller

Time-multiplexed scan controller for the 8-digit common-anode FND on the time-clock board. Every digit slot is split into a blanking interval and a drive interval. The block owns the digit-position sequence, decodes each 4-bit digit value to segments, and applies decimal-point and blink masks. Inputs are snapshotted once per frame so the display never tears. It sits between the timekeeping/setting logic and the FND pins.

## Interface
- SCAN_DIV, 100000: clocks per digit slot, covering blank plus drive; must be ≥ 2.
- BLANK_CYCLES, 1000: clocks at the start of each slot with all digits off; range 1 … SCAN_DIV-1.
- BLINK_DIV, 50000000: clocks per blink half-period.
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  scan enable; low forces the idle state.
- i_digitData  in  32  nibble k (bits 4k+3:4k) is the value for digit k.
- i_dpMask  in  8  bit k = 1 lights the decimal point of digit k.
- i_blinkMask  in  8  bit k = 1 blanks digit k during the blink OFF phase.
- o_fndCom  out  8  digit commons, active-low, one-hot or all-ones.
- o_fndFont  out  8  segments, active-low; [0]=a … [6]=g, [7]=dp.
- o_digitPosition  out  3  index of the digit in the current slot.
- o_frameStart  out  1  one-cycle pulse in slot 0, cycle 0 of every frame.

## Operation
- States: IDLE, BLANK, DRIVE.
  - IDLE is entered on reset or when i_enable = 0.
  - In IDLE, the slot counter = 0, position = 0, outputs are at reset values, and the blink counter keeps running.
- IDLE → BLANK on the first edge with i_enable = 1. That edge starts slot 0 of position 0.
- BLANK → DRIVE after BLANK_CYCLES clocks in the slot.
- DRIVE → BLANK at the end of the slot (slot counter = SCAN_DIV-1). On that edge the position increments modulo 8 (7 wraps to 0).
- Frame = 8 slots = 8·SCAN_DIV clocks.
- Snapshot: i_digitData, i_dpMask and i_blinkMask are registered on the edge that starts position 0, slot cycle 0. This is the same edge that asserts o_frameStart. Mid-frame input changes show up only in the next frame.
- BLANK: o_fndCom = 8'hFF, o_fndFont = 8'hFF; o_digitPosition already shows the new position.
- DRIVE for position p:
  - o_fndCom = ~(8'b1 << p).
  - o_fndFont[6:0] = hex decode of snapshot nibble p (0–9, A, b, C, d, E, F); o_fndFont[7] = ~dp[p].
- Blink:
  - The blink counter wraps at BLINK_DIV-1 and toggles the phase. Phase = ON after reset.
  - When phase = OFF and blink[p] = 1, o_fndFont = 8'hFF for the whole slot; o_fndCom behaves normally.
  - A phase change takes effect on the next clock, even mid-slot.
- i_enable falling in any state: the next edge returns to IDLE and outputs go blank.
- Reset asserted mid-operation: all registers take their reset values immediately (asynchronous), without waiting for a clock edge.

## Timing
- Reset values: o_fndCom = 8'hFF, o_fndFont = 8'hFF, o_digitPosition = 0, o_frameStart = 0; blink phase = ON, blink counter = 0.
- All outputs are registered and update on the same edge as the state and slot counter. There is no extra pipeline stage.
- In slot cycle s (0 … SCAN_DIV-1):
  - s < BLANK_CYCLES → blank.
  - Otherwise → drive.
- Exactly one common is low in DRIVE; none is low in BLANK or IDLE. There are never two digits on at once.
- o_frameStart is high only in the cycle after the snapshot edge, once per 8·SCAN_DIV clocks.

## Configuration
- Macro: FND_LEADING_ZERO_BLANK_EN. It controls leading-zero suppression.
- Defined:
  - A digit k (k = 7 … 1) is suppressed when snapshot nibbles k … 7 are all 0.
  - A suppressed digit outputs o_fndFont = 8'hFF for its whole slot, including DP.
  - Suppression is computed from the snapshot.
  - Digit 0 is never suppressed.
- Not defined: every digit is decoded, with zeros shown as "0".

## Test plan
All cases use SCAN_DIV = 8, BLANK_CYCLES = 2, BLINK_DIV = 64.
- Reset then enable: reset asserted → outputs FF/FF/0/0. Release with i_enable = 1 → o_frameStart pulses one cycle. Cycles 0–1 are blank; cycles 2–7 show com = 8'hFE. Position 1 starts at clock 8; o_frameStart repeats every 64 clocks.
- Decode and DP: i_digitData = 32'h0123_4567, i_dpMask = 8'h04. Digit 0 font = 8'hF8 ("7"); digit 2 font = 8'h12 ("5" with DP); digit 7 font = 8'hC0 ("0", macro off).
- Snapshot: change i_digitData during slot 3 → slots 3–7 keep the old value; the new value appears only after the next o_frameStart.
- Blink: i_blinkMask = 8'h01, phase OFF (clocks 64–127) → digit 0 font = 8'hFF while com still goes low. Other digits are unaffected; digit 0 returns when phase = ON.
- Leading zeros (macro on): i_digitData = 32'h0000_0102 → digits 7–3 font = 8'hFF; digit 2 shows "1", digit 1 shows "0", digit 0 shows "2". With i_digitData = 0, only digit 0 shows "0".
- Disable and reset mid-slot:
  - i_enable low at slot 5, cycle 4 → next edge blank/position 0; re-enable → new frame from position 0.
  - i_reset_n low mid-drive → outputs FF/FF immediately, before the next clock edge.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 8-digit common-anode FND scan controller with per-frame input snapshot.
// Optional leading-zero suppression is enabled by defining FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_controller #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned BLINK_DIV    = 50000000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic [31:0] i_digitData,
    input  logic [7:0]  i_dpMask,
    input  logic [7:0]  i_blinkMask,
    output logic [7:0]  o_fndCom,
    output logic [7:0]  o_fndFont,
    output logic [2:0]  o_digitPosition,
    output logic        o_frameStart
);

    localparam int unsigned SlotW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SlotW-1:0]  SlotLast  = SlotW'(SCAN_DIV - 1);
    localparam logic [SlotW-1:0]  BlankLast = SlotW'(BLANK_CYCLES - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StDrive
    } state_e;

    state_e            state;
    logic [SlotW-1:0]  slot_cnt;
    logic [2:0]        position;
    logic [BlinkW-1:0] blink_cnt;
    logic              blink_off;
    logic [31:0]       snap_data;
    logic [7:0]        snap_dp;
    logic [7:0]        snap_blink;

    logic [7:0]        suppress;
    logic [3:0]        cur_nibble;
    logic [7:0]        drive_com;
    logic [7:0]        drive_font;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

`ifdef FND_LEADING_ZERO_BLANK_EN
    // Digit k is suppressed when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic zero_above;
        suppress   = 8'h00;
        zero_above = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            zero_above  = zero_above & (snap_data[4*k +: 4] == 4'h0);
            suppress[k] = zero_above;
        end
    end
`else
    assign suppress = 8'h00;
`endif

    always_comb begin
        cur_nibble = snap_data[{position, 2'b00} +: 4];
        drive_com  = ~(8'h01 << position);
        drive_font = {~snap_dp[position], hex_seg(cur_nibble)};
        if ((blink_off && snap_blink[position]) || suppress[position]) begin
            drive_font = 8'hFF;
        end
    end

    assign o_digitPosition = position;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= StIdle;
            slot_cnt     <= '0;
            position     <= 3'd0;
            blink_cnt    <= '0;
            blink_off    <= 1'b0;
            snap_data    <= 32'h0;
            snap_dp      <= 8'h00;
            snap_blink   <= 8'h00;
            o_fndCom     <= 8'hFF;
            o_fndFont    <= 8'hFF;
            o_frameStart <= 1'b0;
        end else begin
            // Blink timebase runs in every state, including idle.
            if (blink_cnt == BlinkLast) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            o_frameStart <= 1'b0;

            if (!i_enable) begin
                state     <= StIdle;
                slot_cnt  <= '0;
                position  <= 3'd0;
                o_fndCom  <= 8'hFF;
                o_fndFont <= 8'hFF;
            end else begin
                case (state)
                    StIdle: begin
                        state        <= StBlank;
                        slot_cnt     <= '0;
                        position     <= 3'd0;
                        snap_data    <= i_digitData;
                        snap_dp      <= i_dpMask;
                        snap_blink   <= i_blinkMask;
                        o_frameStart <= 1'b1;
                        o_fndCom     <= 8'hFF;
                        o_fndFont    <= 8'hFF;
                    end
                    StBlank: begin
                        slot_cnt <= slot_cnt + 1'b1;
                        if (slot_cnt == BlankLast) begin
                            state     <= StDrive;
                            o_fndCom  <= drive_com;
                            o_fndFont <= drive_font;
                        end
                    end
                    StDrive: begin
                        if (slot_cnt == SlotLast) begin
                            state     <= StBlank;
                            slot_cnt  <= '0;
                            position  <= position + 3'd1;
                            o_fndCom  <= 8'hFF;
                            o_fndFont <= 8'hFF;
                            if (position == 3'd7) begin
                                snap_data    <= i_digitData;
                                snap_dp      <= i_dpMask;
                                snap_blink   <= i_blinkMask;
                                o_frameStart <= 1'b1;
                            end
                        end else begin
                            slot_cnt  <= slot_cnt + 1'b1;
                            o_fndCom  <= drive_com;
                            o_fndFont <= drive_font;
                        end
                    end
                    default: begin
                        state     <= StIdle;
                        o_fndCom  <= 8'hFF;
                        o_fndFont <= 8'hFF;
                    end
                endcase
            end
        end
    end

endmodule
